// File: rtl/operand_packer_pkg.sv
// Shared NPU operand-path definitions for operand_packer and adder_tree.
package operand_packer_pkg;

    localparam int NPU_DATA_WIDTH = 24;
    localparam int NPU_INPUT_NUM  = 15;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // LSB position of lane k in a packed bus of w-bit lanes.
    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/operand_packer.sv
// Packs a serial signed operand stream into one INPUT_NUM-lane vector; m_valid rises 1 cycle after the closing beat.
// Backpressure: s_ready follows m_ready while a group is held; a same-cycle drain and refill costs no bubble.
module operand_packer
    import operand_packer_pkg::*;
#(
    parameter int INPUT_NUM        = NPU_INPUT_NUM,
    parameter int INPUT_DATA_WIDTH = NPU_DATA_WIDTH,
    parameter int CNT_WIDTH        = $clog2(INPUT_NUM + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic signed [INPUT_DATA_WIDTH-1:0]    s_data,
    input  logic                                  s_last,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [INPUT_NUM*INPUT_DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]                  m_count,
    output logic                                  m_last
);

    localparam int DW = INPUT_NUM * INPUT_DATA_WIDTH;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   idx;
    logic [DW-1:0]          lane_buf;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   last_q;
    logic                   in_fire;
    logic                   out_fire;
    logic                   closes;

    assign s_ready  = (state == FILL) | m_ready;
    assign m_valid  = (state == HOLD);
    assign in_fire  = s_valid & s_ready;
    assign out_fire = m_valid & m_ready;
    // idx is 0 while holding, so this also covers the refill beat and INPUT_NUM==1.
    assign closes   = s_last | (idx == CNT_WIDTH'(INPUT_NUM - 1));

    assign m_data  = lane_buf;
    assign m_count = cnt_q;
    assign m_last  = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            idx      <= '0;
            lane_buf <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_fire) begin
                        lane_buf[lane_lsb(int'(idx), INPUT_DATA_WIDTH) +: INPUT_DATA_WIDTH] <= s_data;
                        if (closes) begin
                            state  <= HOLD;
                            idx    <= '0;
                            cnt_q  <= idx + 1'b1;
                            last_q <= s_last;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        lane_buf <= '0;
                        if (in_fire) begin
                            lane_buf[INPUT_DATA_WIDTH-1:0] <= s_data;
                        end
                        if (in_fire && closes) begin
                            state  <= HOLD;
                            idx    <= '0;
                            cnt_q  <= CNT_WIDTH'(1);
                            last_q <= s_last;
                        end else if (in_fire) begin
                            state  <= FILL;
                            idx    <= CNT_WIDTH'(1);
                            cnt_q  <= '0;
                            last_q <= 1'b0;
                        end else begin
                            state  <= FILL;
                            idx    <= '0;
                            cnt_q  <= '0;
                            last_q <= 1'b0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: doc/operand_packer.md
Name: operand_packer

Overview:
- Upstream of the adder tree: turns a serial valid/ready stream of signed operands into one packed N-lane vector.
- Its output port shape is exactly the adder tree's `din` bus, so the adder tree's combinational result can be registered off the output.
- Supports partial final groups: unused lanes are zero-filled, which is neutral for summation.
- Provides a lane count and an end-of-group flag for the downstream accumulator/controller.

Parameters:
- INPUT_NUM, 15, lanes per packed group (≥1).
- INPUT_DATA_WIDTH, 24, signed operand width in bits.
- CNT_WIDTH, $clog2(INPUT_NUM+1), width of the valid-lane count.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  packer can accept a beat.
- s_data  input  INPUT_DATA_WIDTH  signed operand.
- s_last  input  1  beat closes the current group, full or not.
- m_valid  output  1  packed group valid.
- m_ready  input  1  downstream accepts group.
- m_data  output  INPUT_NUM*INPUT_DATA_WIDTH  lane k at bits [k*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]; zero beyond m_count.
- m_count  output  CNT_WIDTH  number of populated lanes, 1..INPUT_NUM.
- m_last  output  1  group was closed by s_last.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State=FILL, lane index idx=0, lane buffer cleared to all zeros.
  - m_valid=0, m_data=0, m_count=0, m_last=0.
  - s_ready reads 1 in the first cycle after reset.
- States:
  - FILL: collecting beats.
  - HOLD: group presented, m_valid=1.
- s_ready is combinational: 1 in FILL; equal to m_ready in HOLD. No combinational path from s_valid to s_ready.
- Accept: in_fire = s_valid & s_ready. Out_fire = m_valid & m_ready.
- FILL, in_fire:
  - Write s_data to lane idx.
  - If idx==INPUT_NUM-1 or s_last:
    - Next state is HOLD.
    - m_count=idx+1, m_last=s_last.
    - m_valid rises on the next cycle.
  - Otherwise idx<=idx+1.
- HOLD:
  - m_data, m_count and m_last are stable while m_valid & !m_ready.
  - On out_fire without in_fire: buffer cleared to zeros, idx=0, state→FILL, m_valid=0 next cycle.
  - On out_fire with in_fire (same cycle):
    - Buffer cleared, and the new beat is written to lane 0.
    - idx=1, state→FILL.
    - If that beat closes a group (s_last, or INPUT_NUM==1), go directly to HOLD with count 1.
    - No bubble: sustained throughput is one beat per cycle.
- Latency: the final beat of a group is accepted at cycle t; m_valid=1 at cycle t+1.
- Arithmetic: none. Data is passed bit-exact (two's complement preserved); padding lanes are exactly 0.
- Boundaries:
  - INPUT_NUM==1: every accepted beat forms a full group.
  - s_last on the INPUT_NUM-th beat: full group with m_last=1.
  - s_valid high with m_ready low in HOLD: beat is not accepted; upstream holds it.
  - rst mid-group or during HOLD: the partial or pending group is discarded and never emitted.
  - m_ready is ignored while m_valid=0.
  - s_data and s_last are don't-care when s_valid=0.

Decomposition:
- Shared package/header holds:
  - NPU operand width default (24) and lane count default (15), also used by adder_tree.
  - State encoding localparams FILL=1'b0, HOLD=1'b1.
  - Lane slice macro/function for [k*W +: W] indexing.
- No sub-module: the lane buffer, index counter and 2-state FSM fit in one module (~150 lines).
- adder_tree is instantiated by the parent, not inside this block.

Test Plan:
- Full group: stream 1..15 with m_ready=1 → one group:
  - lane k = k+1, m_count=15, m_last=0.
  - m_valid one cycle after the 15th accept.
  - Downstream adder_tree dout=120.
- Partial group: beats 5, -3, 7, 2 with s_last on 2 →
  - lanes 0..3 = 5, -3, 7, 2; lanes 4..14 = 0.
  - m_count=4, m_last=1, tree sum 11.
- Backpressure:
  - Complete a group, then hold m_ready=0 for 3 cycles with s_valid=1 (next value 99) → m_data constant, s_ready=0, beat not consumed.
  - Raise m_ready → 99 accepted the same cycle into lane 0 of the next group; other lanes 0.
- Back-to-back: 30 beats of value -2^23, s_valid=1 and m_ready=1 continuously →
  - two full groups, 30 consecutive in_fire cycles.
  - Each tree sum = -15·2^23 = -125829120 (fits in 28 bits).
- Reset mid-operation:
  - 7 beats of value 8, then rst=1 for one cycle, then 15 beats of value 1 → exactly one group, all lanes 1, m_count=15, no residual 8.
  - m_valid=0, m_count=0 and s_ready=1 during and right after reset.
- Single-lane close: idle FILL, one beat 42 with s_last → lane 0=42, rest 0, m_count=1, m_last=1.
